fetch_stage: RTL and testbench

- Instruction-fetch stage plus the F2D pipeline register. It owns the 32-bit PC, addresses the 16-bit instruction memory and presents the instruction word, PC+1 and the interrupt marker to decode.
- Later stages drive it back with three kinds of redirect: branch redirect, two-phase RET/RTI PC restore from popped stack data, and interrupt vectoring.
- It also handles the reset-time PC boot load from memory words 0 and 1.

---
 rtl/fetch_stage.sv | 162 ++++++++++++++++
 tb/tb_fetch_stage.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage and the F2D pipeline register. Owns the PC, boots
//   it from instruction memory words 0 and 1, fetches one 16-bit word per
//   cycle and hands decode the word, PC+1 and an interrupt marker. Later
//   stages redirect it with branches, a two-phase RET/RTI PC restore from
//   popped stack words, and interrupt vectoring.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   imem_addr       address into instruction memory (combinational read)
//   imem_data       word at imem_addr, same cycle
//   stall           hazard bubble from decode: hold PC and F2D
//   branch_taken    taken branch resolved in execute
//   branch_target   target PC for branch_taken
//   ret_hi_valid    first RET/RTI pop, pop_data = PC[31:16]
//   ret_lo_valid    second RET/RTI pop, pop_data = PC[15:0]
//   pop_data        popped stack word
//   int_req         external interrupt request (level or pulse)
//   int_redirect    interrupt push sequence finished, jump to INT_VECTOR
//   instr_f2d       F2D instruction word
//   pc_f2d          F2D PC (PC+1 of the fetched word, or the interrupted PC)
//   int_f2d         F2D interrupt marker
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int             PC_W       = 32,
    parameter int             IW         = 16,
    parameter logic [IW-1:0]  NOP_WORD   = 16'h0000,
    parameter logic [PC_W-1:0] INT_VECTOR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] imem_addr,
    input  logic [IW-1:0]   imem_data,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            ret_hi_valid,
    input  logic            ret_lo_valid,
    input  logic [15:0]     pop_data,
    input  logic            int_req,
    input  logic            int_redirect,
    output logic [IW-1:0]   instr_f2d,
    output logic [PC_W-1:0] pc_f2d,
    output logic            int_f2d
);

    typedef enum logic [2:0] {
        BOOT_HI,
        BOOT_LO,
        RUN,
        RET_WAIT,
        INT_WAIT
    } state_t;

    state_t          state_p0;
    logic [PC_W-1:0] pc_p0;
    logic            int_pending_p0;

    logic [IW-1:0]   instr_p1;
    logic [PC_W-1:0] pc_p1;
    logic            int_p1;

    // Fetch address: boot words come from fixed locations 0 and 1.
    always_comb begin
        imem_addr = pc_p0;
        case (state_p0)
            BOOT_HI: imem_addr = PC_W'(0);
            BOOT_LO: imem_addr = PC_W'(1);
            default: imem_addr = pc_p0;
        endcase
    end

    // ---- fetch (p0) -> F2D register (p1) ----
    // A bubble clears the whole F2D register back to its reset contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0       <= BOOT_HI;
            pc_p0          <= '0;
            int_pending_p0 <= 1'b0;
            instr_p1       <= NOP_WORD;
            pc_p1          <= '0;
            int_p1         <= 1'b0;
        end else begin
            case (state_p0)
                BOOT_HI: begin
                    pc_p0[PC_W-1 -: 16] <= imem_data;
                    state_p0            <= BOOT_LO;
                end

                BOOT_LO: begin
                    pc_p0[15:0] <= imem_data;
                    state_p0    <= RUN;
                end

                RUN: begin
                    if (branch_taken) begin
                        pc_p0    <= branch_target;
                        instr_p1 <= NOP_WORD;
                        pc_p1    <= '0;
                        int_p1   <= 1'b0;
                    end else if (ret_hi_valid) begin
                        pc_p0[PC_W-1 -: 16] <= pop_data;
                        instr_p1            <= NOP_WORD;
                        pc_p1               <= '0;
                        int_p1              <= 1'b0;
                        state_p0            <= RET_WAIT;
                    end else if (stall) begin
                        // hold PC and F2D
                    end else if (int_pending_p0) begin
                        // Marker carries the unfetched PC so RTI resumes there.
                        instr_p1       <= NOP_WORD;
                        pc_p1          <= pc_p0;
                        int_p1         <= 1'b1;
                        int_pending_p0 <= 1'b0;
                        state_p0       <= INT_WAIT;
                    end else begin
                        instr_p1 <= imem_data;
                        pc_p1    <= pc_p0 + PC_W'(1);
                        int_p1   <= 1'b0;
                        pc_p0    <= pc_p0 + PC_W'(1);
                    end
                end

                RET_WAIT: begin
                    instr_p1 <= NOP_WORD;
                    pc_p1    <= '0;
                    int_p1   <= 1'b0;
                    if (ret_lo_valid) begin
                        pc_p0[15:0] <= pop_data;
                        state_p0    <= RUN;
                    end
                end

                INT_WAIT: begin
                    instr_p1 <= NOP_WORD;
                    pc_p1    <= '0;
                    int_p1   <= 1'b0;
                    if (branch_taken) begin
                        // An older branch squashed the marker: re-arm it.
                        pc_p0          <= branch_target;
                        int_pending_p0 <= 1'b1;
                        state_p0       <= RUN;
                    end else if (int_redirect) begin
                        pc_p0    <= INT_VECTOR;
                        state_p0 <= RUN;
                    end
                end

                default: state_p0 <= BOOT_HI;
            endcase

            // A request arriving in the marker cycle itself is kept, not lost.
            if (int_req) int_pending_p0 <= 1'b1;
        end
    end

    assign instr_f2d = instr_p1;
    assign pc_f2d    = pc_p1;
    assign int_f2d   = int_p1;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [15:0] NOP = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [15:0] imem_data;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        ret_hi_valid;
    logic        ret_lo_valid;
    logic [15:0] pop_data;
    logic        int_req;
    logic        int_redirect;
    logic [15:0] instr_f2d;
    logic [31:0] pc_f2d;
    logic        int_f2d;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        rhi;
        logic        rlo;
        logic [15:0] pop;
        logic        ireq;
        logic        iredir;
    } stim_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] instr;
        logic [31:0] pcf;
        logic        intf;
    } vec_t;

    stim_t stim_q[$];
    vec_t  exp_q[$];

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .ret_hi_valid (ret_hi_valid),
        .ret_lo_valid (ret_lo_valid),
        .pop_data     (pop_data),
        .int_req      (int_req),
        .int_redirect (int_redirect),
        .instr_f2d    (instr_f2d),
        .pc_f2d       (pc_f2d),
        .int_f2d      (int_f2d)
    );

    // Instruction memory: boot words at 0/1, a known word at 0x10, a
    // scrambled address pattern everywhere else.
    function automatic logic [15:0] mem_f(input logic [31:0] a);
        if (a == 32'h0)  return 16'h0000;
        if (a == 32'h1)  return 16'h0010;
        if (a == 32'h10) return 16'hA123;
        return a[15:0] ^ 16'h5A00;
    endfunction

    assign imem_data = mem_f(imem_addr);

    function automatic stim_t st(input logic r, input logic s, input logic b,
                                 input logic [31:0] t, input logic hi, input logic lo,
                                 input logic [15:0] p, input logic iq, input logic ir);
        return '{rst: r, stall: s, br: b, tgt: t, rhi: hi, rlo: lo, pop: p, ireq: iq, iredir: ir};
    endfunction

    function automatic vec_t v(input logic [31:0] a, input logic [15:0] i,
                               input logic [31:0] p, input logic f);
        return '{addr: a, instr: i, pcf: p, intf: f};
    endfunction

    function automatic stim_t idle();
        return st(0, 0, 0, 32'h0, 0, 0, 16'h0, 0, 0);
    endfunction

    task automatic add(input stim_t s, input vec_t e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic drive(input stim_t s);
        rst           = s.rst;
        stall         = s.stall;
        branch_taken  = s.br;
        branch_target = s.tgt;
        ret_hi_valid  = s.rhi;
        ret_lo_valid  = s.rlo;
        pop_data      = s.pop;
        int_req       = s.ireq;
        int_redirect  = s.iredir;
    endtask

    task automatic test_reset();
        vec_t e, o;
        int   row = 0;
        add(st(1, 0, 0, 32'h0, 0, 0, 16'h0, 0, 0), v(32'h0, NOP, 32'h0, 0));
        // int_req and ret_lo under reset must leave no trace
        add(st(1, 1, 1, 32'h55, 0, 1, 16'h1, 1, 1), v(32'h0, NOP, 32'h0, 0));
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            @(posedge clk); #1;
            e = exp_q.pop_front();
            o = v(imem_addr, instr_f2d, pc_f2d, int_f2d);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL reset row %0d: got addr=%h instr=%h pc_f2d=%h int=%b, want addr=%h instr=%h pc_f2d=%h int=%b",
                         row, o.addr, o.instr, o.pcf, o.intf, e.addr, e.instr, e.pcf, e.intf);
            end
            row++;
        end
    endtask

    task automatic test_boot();
        vec_t e, o;
        int   row = 0;
        // stall and branch during boot are ignored
        add(st(0, 1, 1, 32'h99, 0, 0, 16'h0, 0, 0), v(32'h1, NOP, 32'h0, 0));
        add(idle(), v(32'h10, NOP, 32'h0, 0));
        add(idle(), v(32'h11, 16'hA123, 32'h11, 0));
        add(idle(), v(32'h12, mem_f(32'h11), 32'h12, 0));
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            @(posedge clk); #1;
            e = exp_q.pop_front();
            o = v(imem_addr, instr_f2d, pc_f2d, int_f2d);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL boot row %0d: got addr=%h instr=%h pc_f2d=%h int=%b, want addr=%h instr=%h pc_f2d=%h int=%b",
                         row, o.addr, o.instr, o.pcf, o.intf, e.addr, e.instr, e.pcf, e.intf);
            end
            row++;
        end
    endtask

    task automatic test_stall();
        vec_t e, o;
        int   row = 0;
        add(st(0, 1, 0, 32'h0, 0, 0, 16'h0, 0, 0), v(32'h12, mem_f(32'h11), 32'h12, 0));
        add(st(0, 1, 0, 32'h0, 0, 0, 16'h0, 0, 0), v(32'h12, mem_f(32'h11), 32'h12, 0));
        add(idle(), v(32'h13, mem_f(32'h12), 32'h13, 0));
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            @(posedge clk); #1;
            e = exp_q.pop_front();
            o = v(imem_addr, instr_f2d, pc_f2d, int_f2d);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL stall row %0d: got addr=%h instr=%h pc_f2d=%h int=%b, want addr=%h instr=%h pc_f2d=%h int=%b",
                         row, o.addr, o.instr, o.pcf, o.intf, e.addr, e.instr, e.pcf, e.intf);
            end
            row++;
        end
    endtask

    task automatic test_branch();
        vec_t e, o;
        int   row = 0;
        add(st(0, 1, 1, 32'h40, 0, 0, 16'h0, 0, 0), v(32'h40, NOP, 32'h0, 0));
        add(idle(), v(32'h41, mem_f(32'h40), 32'h41, 0));
        // PC wraps modulo 2^32
        add(st(0, 0, 1, 32'hFFFF_FFFF, 0, 0, 16'h0, 0, 0), v(32'hFFFF_FFFF, NOP, 32'h0, 0));
        add(idle(), v(32'h0, 16'hA5FF, 32'h0, 0));
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            @(posedge clk); #1;
            e = exp_q.pop_front();
            o = v(imem_addr, instr_f2d, pc_f2d, int_f2d);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL branch row %0d: got addr=%h instr=%h pc_f2d=%h int=%b, want addr=%h instr=%h pc_f2d=%h int=%b",
                         row, o.addr, o.instr, o.pcf, o.intf, e.addr, e.instr, e.pcf, e.intf);
            end
            row++;
        end
    endtask

    task automatic test_interrupt();
        vec_t e, o;
        int   row = 0;
        add(st(0, 0, 1, 32'h1F, 0, 0, 16'h0, 0, 0), v(32'h1F, NOP, 32'h0, 0));
        add(st(0, 0, 0, 32'h0, 0, 0, 16'h0, 1, 0), v(32'h20, mem_f(32'h1F), 32'h20, 0));
        add(idle(), v(32'h20, NOP, 32'h20, 1));
        add(idle(), v(32'h20, NOP, 32'h0, 0));
        add(st(0, 0, 0, 32'h0, 0, 0, 16'h0, 0, 1), v(32'h0, NOP, 32'h0, 0));
        add(idle(), v(32'h1, 16'h0000, 32'h1, 0));
        // marker squashed by an older branch (branch beats int_redirect)
        add(st(0, 0, 1, 32'h30, 0, 0, 16'h0, 0, 0), v(32'h30, NOP, 32'h0, 0));
        add(st(0, 0, 0, 32'h0, 0, 0, 16'h0, 1, 0), v(32'h31, mem_f(32'h30), 32'h31, 0));
        add(idle(), v(32'h31, NOP, 32'h31, 1));
        add(st(0, 0, 1, 32'h50, 0, 0, 16'h0, 0, 1), v(32'h50, NOP, 32'h0, 0));
        add(st(0, 1, 0, 32'h0, 0, 0, 16'h0, 0, 0), v(32'h50, NOP, 32'h0, 0));
        add(idle(), v(32'h50, NOP, 32'h50, 1));
        add(st(0, 0, 0, 32'h0, 0, 0, 16'h0, 0, 1), v(32'h0, NOP, 32'h0, 0));
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            @(posedge clk); #1;
            e = exp_q.pop_front();
            o = v(imem_addr, instr_f2d, pc_f2d, int_f2d);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL interrupt row %0d: got addr=%h instr=%h pc_f2d=%h int=%b, want addr=%h instr=%h pc_f2d=%h int=%b",
                         row, o.addr, o.instr, o.pcf, o.intf, e.addr, e.instr, e.pcf, e.intf);
            end
            row++;
        end
    endtask

    task automatic test_ret();
        vec_t e, o;
        int   row = 0;
        add(st(0, 0, 0, 32'h0, 1, 0, 16'h0001, 0, 0), v(32'h0001_0000, NOP, 32'h0, 0));
        add(idle(), v(32'h0001_0000, NOP, 32'h0, 0));
        // branch and stall are ignored while waiting for the low half
        add(st(0, 1, 1, 32'h77, 0, 0, 16'h0, 0, 0), v(32'h0001_0000, NOP, 32'h0, 0));
        add(idle(), v(32'h0001_0000, NOP, 32'h0, 0));
        add(st(0, 0, 0, 32'h0, 0, 1, 16'h2000, 0, 0), v(32'h0001_2000, NOP, 32'h0, 0));
        add(idle(), v(32'h0001_2001, 16'h7A00, 32'h0001_2001, 0));
        // stray ret_lo_valid in RUN does nothing
        add(st(0, 0, 0, 32'h0, 0, 1, 16'hBEEF, 0, 0), v(32'h0001_2002, 16'h7A01, 32'h0001_2002, 0));
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            @(posedge clk); #1;
            e = exp_q.pop_front();
            o = v(imem_addr, instr_f2d, pc_f2d, int_f2d);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL ret row %0d: got addr=%h instr=%h pc_f2d=%h int=%b, want addr=%h instr=%h pc_f2d=%h int=%b",
                         row, o.addr, o.instr, o.pcf, o.intf, e.addr, e.instr, e.pcf, e.intf);
            end
            row++;
        end
    endtask

    task automatic test_reset_mid_ret();
        vec_t e, o;
        int   row = 0;
        add(st(0, 0, 0, 32'h0, 1, 0, 16'h0003, 0, 0), v(32'h0003_2002, NOP, 32'h0, 0));
        add(st(1, 0, 0, 32'h0, 0, 1, 16'h1111, 0, 0), v(32'h0, NOP, 32'h0, 0));
        // late ret_lo is ignored in boot; int_req during boot is latched
        add(st(0, 1, 0, 32'h0, 0, 1, 16'h1234, 1, 0), v(32'h1, NOP, 32'h0, 0));
        add(idle(), v(32'h10, NOP, 32'h0, 0));
        add(idle(), v(32'h10, NOP, 32'h10, 1));
        add(st(0, 0, 0, 32'h0, 0, 0, 16'h0, 0, 1), v(32'h0, NOP, 32'h0, 0));
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            @(posedge clk); #1;
            e = exp_q.pop_front();
            o = v(imem_addr, instr_f2d, pc_f2d, int_f2d);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL reset_mid_ret row %0d: got addr=%h instr=%h pc_f2d=%h int=%b, want addr=%h instr=%h pc_f2d=%h int=%b",
                         row, o.addr, o.instr, o.pcf, o.intf, e.addr, e.instr, e.pcf, e.intf);
            end
            row++;
        end
    endtask

    initial begin
        drive(st(1, 0, 0, 32'h0, 0, 0, 16'h0, 0, 0));
        test_reset();
        test_boot();
        test_stall();
        test_branch();
        test_interrupt();
        test_ret();
        test_reset_mid_ret();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
